// File: rtl/shared_bus_arbiter.sv
// Shared-bus arbiter: round-robin grant, fixed-latency snoop window, combined
// snoop result and writeback hand-off to a modified-line owner before the data phase.
module shared_bus_arbiter #(
  parameter int REQUESTERS = 4,
  parameter int SNOOP_WAIT = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REQUESTERS-1:0]     req,
  input  logic                      cmd_valid,
  input  logic [7:0]                operation,
  input  logic [2*REQUESTERS-1:0]   snoop_result,
  input  logic                      done,
  output logic [REQUESTERS-1:0]     gnt,
  output logic                      snoop_strobe,
  output logic [1:0]                snoop_summary,
  output logic [REQUESTERS-1:0]     owner,
  output logic                      busy,
  output logic                      protocol_error
);

  localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam logic [7:0] OP_INVALIDATE = 8'h03;

  // IDLE: no owner | GRANT: await command | SNOOP_WAIT: snoop window
  // WRITEBACK: HITM snooper drives data | DATA: requester drives data
  typedef enum logic [2:0] {
    ST_IDLE, ST_GRANT, ST_SNOOP_WAIT, ST_WRITEBACK, ST_DATA
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [3:0]      cnt;
  logic [7:0]      op_reg;

  logic                  found_hi, found_lo, win_found;
  logic [PW-1:0]         idx_hi, idx_lo, win_idx;
  logic [REQUESTERS-1:0] win_onehot;
  logic [PW-1:0]         ptr_next;

  // Search at-or-above ptr first, then wrap to the low indices.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (!found_hi && req[i] && (PW'(i) >= ptr)) begin
        found_hi = 1'b1;
        idx_hi   = PW'(i);
      end
      if (!found_lo && req[i]) begin
        found_lo = 1'b1;
        idx_lo   = PW'(i);
      end
    end
    win_found  = found_hi | found_lo;
    win_idx    = found_hi ? idx_hi : idx_lo;
    win_onehot = {{(REQUESTERS-1){1'b0}}, 1'b1} << win_idx;
    ptr_next   = (win_idx == PW'(REQUESTERS-1)) ? '0 : win_idx + PW'(1);
  end

  logic                  hitm_any, hitm_multi, hit_any;
  logic [REQUESTERS-1:0] snooper;

  // The master's own field is masked; 11 falls through as NOHIT.
  always_comb begin
    hitm_any   = 1'b0;
    hitm_multi = 1'b0;
    hit_any    = 1'b0;
    snooper    = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (!gnt[i]) begin
        if (snoop_result[2*i +: 2] == 2'b10) begin
          if (hitm_any) hitm_multi = 1'b1;
          else          snooper[i] = 1'b1;
          hitm_any = 1'b1;
        end else if (snoop_result[2*i +: 2] == 2'b01) begin
          hit_any = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      ptr            <= '0;
      cnt            <= '0;
      op_reg         <= '0;
      gnt            <= '0;
      owner          <= '0;
      snoop_strobe   <= 1'b0;
      snoop_summary  <= 2'b00;
      busy           <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      snoop_strobe <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            gnt   <= win_onehot;
            ptr   <= ptr_next;
            busy  <= 1'b1;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (cmd_valid) begin
            op_reg       <= operation;
            cnt          <= 4'(SNOOP_WAIT);
            snoop_strobe <= 1'b1;
            state        <= ST_SNOOP_WAIT;
          end else if ((req & gnt) == '0) begin
            gnt   <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_SNOOP_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            snoop_summary <= hitm_any ? 2'b10 : (hit_any ? 2'b01 : 2'b00);
            if (hitm_multi) protocol_error <= 1'b1;
            if (hitm_any) begin
              owner <= snooper;
              state <= ST_WRITEBACK;
            end else if (op_reg == OP_INVALIDATE) begin
              gnt   <= '0;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              owner <= gnt;
              state <= ST_DATA;
            end
          end
        end
        ST_WRITEBACK: begin
          if (done) begin
            if (op_reg == OP_INVALIDATE) begin
              gnt   <= '0;
              owner <= '0;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              owner <= gnt;
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (done) begin
            gnt   <= '0;
            owner <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          gnt   <= '0;
          owner <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Bench for shared_bus_arbiter: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_shared_bus_arbiter;
  localparam int R  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [R-1:0]   req;
  logic           cmd_valid;
  logic [7:0]     operation;
  logic [2*R-1:0] snoop_result;
  logic           done;
  logic [R-1:0]   gnt;
  logic           snoop_strobe;
  logic [1:0]     snoop_summary;
  logic [R-1:0]   owner;
  logic           busy;
  logic           protocol_error;

  shared_bus_arbiter #(.REQUESTERS(R), .SNOOP_WAIT(SW)) dut (
    .clk(clk), .reset(rst), .req(req), .cmd_valid(cmd_valid), .operation(operation),
    .snoop_result(snoop_result), .done(done), .gnt(gnt), .snoop_strobe(snoop_strobe),
    .snoop_summary(snoop_summary), .owner(owner), .busy(busy),
    .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Transaction-level model: who holds the bus, how long since the command,
  // and who (if anyone) drives the data phase.
  localparam int PH_IDLE = 0, PH_CMD = 1, PH_SNOOP = 2, PH_WB = 3, PH_DATA = 4;
  int         m_phase, m_ptr, m_master, m_owner, m_age, m_snooper, m_nhitm, m_nhit, m_f;
  logic [7:0] m_op;
  logic       m_strobe, m_perr;
  logic [1:0] m_summary;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = PH_IDLE; m_ptr = 0; m_master = -1; m_owner = -1; m_age = 0;
      m_op = 8'h00; m_strobe = 1'b0; m_perr = 1'b0; m_summary = 2'b00;
    end else begin
      m_strobe = 1'b0;
      case (m_phase)
        PH_IDLE: if (req != '0) begin
          for (int k = 0; k < R; k++)
            if (m_phase == PH_IDLE && req[(m_ptr + k) % R]) begin
              m_master = (m_ptr + k) % R;
              m_phase  = PH_CMD;
            end
          m_ptr = (m_master + 1) % R;
        end
        PH_CMD: begin
          if (cmd_valid) begin
            m_op = operation; m_age = 0; m_strobe = 1'b1; m_phase = PH_SNOOP;
          end else if (!req[m_master]) begin
            m_master = -1; m_phase = PH_IDLE;
          end
        end
        PH_SNOOP: begin
          m_age++;
          if (m_age == SW + 1) begin
            m_nhitm = 0; m_nhit = 0; m_snooper = -1;
            for (int i = 0; i < R; i++) begin
              m_f = int'(snoop_result[2*i +: 2]);
              if (i != m_master && m_f == 2) begin
                m_nhitm++;
                if (m_snooper < 0) m_snooper = i;
              end else if (i != m_master && m_f == 1) m_nhit++;
            end
            m_summary = (m_nhitm > 0) ? 2'b10 : (m_nhit > 0) ? 2'b01 : 2'b00;
            if (m_nhitm > 1) m_perr = 1'b1;
            if (m_nhitm > 0) begin
              m_owner = m_snooper; m_phase = PH_WB;
            end else if (m_op == 8'h03) begin
              m_master = -1; m_phase = PH_IDLE;
            end else begin
              m_owner = m_master; m_phase = PH_DATA;
            end
          end
        end
        PH_WB: if (done) begin
          if (m_op == 8'h03) begin
            m_master = -1; m_owner = -1; m_phase = PH_IDLE;
          end else begin
            m_owner = m_master; m_phase = PH_DATA;
          end
        end
        PH_DATA: if (done) begin
          m_master = -1; m_owner = -1; m_phase = PH_IDLE;
        end
        default: m_phase = PH_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_gnt",     32'(gnt),            (m_master < 0) ? 32'd0 : 32'd1 << m_master);
      chk("model_owner",   32'(owner),          (m_owner  < 0) ? 32'd0 : 32'd1 << m_owner);
      chk("model_busy",    32'(busy),           32'(m_phase != PH_IDLE));
      chk("model_strobe",  32'(snoop_strobe),   32'(m_strobe));
      chk("model_summary", 32'(snoop_summary),  32'(m_summary));
      chk("model_perr",    32'(protocol_error), 32'(m_perr));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  // One full transaction; own1 = owner after sample (0: no data phase),
  // own2 = owner after the first done (0: transaction ends there).
  task automatic txn(input logic [R-1:0] r, input logic [7:0] op, input logic [2*R-1:0] sr,
                     input logic [R-1:0] exp_gnt, input logic [1:0] exp_sum,
                     input logic [R-1:0] own1, input logic [R-1:0] own2);
    req = r;
    step();
    chk("lit_gnt", 32'(gnt), 32'(exp_gnt));
    cmd_valid = 1'b1; operation = op; snoop_result = sr;
    step();
    chk("lit_strobe", 32'(snoop_strobe), 32'd1);
    cmd_valid = 1'b0;
    step(3);
    chk("lit_summary", 32'(snoop_summary), 32'(exp_sum));
    chk("lit_owner1", 32'(owner), 32'(own1));
    if (own1 != '0) begin
      step(2);
      done = 1'b1;
      step();
      done = 1'b0;
      if (own2 != '0) begin
        chk("lit_owner2", 32'(owner), 32'(own2));
        done = 1'b1;
        step();
        done = 1'b0;
      end
    end
    chk("lit_end_gnt", 32'(gnt), 32'd0);
    chk("lit_end_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = '0; cmd_valid = 1'b0; operation = 8'h00; snoop_result = '0; done = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_perr", 32'(protocol_error), 32'd0);
    rst = 1'b0;
    check_en = 1'b1;

    // Round-robin rotation with all requesting, then wrap from ptr=1.
    txn(4'b1111, 8'h01, 8'h00, 4'b0001, 2'b00, 4'b0001, 4'b0000);
    txn(4'b1111, 8'h01, 8'h00, 4'b0010, 2'b00, 4'b0010, 4'b0000);
    txn(4'b1111, 8'h01, 8'h00, 4'b0100, 2'b00, 4'b0100, 4'b0000);
    txn(4'b1111, 8'h01, 8'h00, 4'b1000, 2'b00, 4'b1000, 4'b0000);
    txn(4'b1111, 8'h01, 8'h00, 4'b0001, 2'b00, 4'b0001, 4'b0000);
    txn(4'b1100, 8'h01, 8'h00, 4'b0100, 2'b00, 4'b0100, 4'b0000);
    // Read with cache 2 HITM: writeback by cache 2, then master 0 data.
    txn(4'b0001, 8'h01, 8'h20, 4'b0001, 2'b10, 4'b0100, 4'b0001);
    // Invalidate by master 1: HIT ends at sample, HITM goes through writeback only.
    txn(4'b0010, 8'h03, 8'h40, 4'b0010, 2'b01, 4'b0000, 4'b0000);
    txn(4'b0010, 8'h03, 8'h80, 4'b0010, 2'b10, 4'b1000, 4'b0000);
    // Two HITMs: lowest index wins, error is sticky.
    txn(4'b0001, 8'h01, 8'h88, 4'b0001, 2'b10, 4'b0010, 4'b0001);
    chk("perr_set", 32'(protocol_error), 32'd1);
    txn(4'b0001, 8'h01, 8'h02, 4'b0001, 2'b00, 4'b0001, 4'b0000);
    chk("perr_sticky", 32'(protocol_error), 32'd1);

    // Asynchronous reset during writeback.
    req = 4'b0001;
    step();
    cmd_valid = 1'b1; operation = 8'h01; snoop_result = 8'h20;
    step();
    cmd_valid = 1'b0;
    step(3);
    chk("wb_owner", 32'(owner), 32'h4);
    #2 rst = 1'b1;
    #1;
    chk("async_gnt", 32'(gnt), 32'd0);
    chk("async_owner", 32'(owner), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_perr", 32'(protocol_error), 32'd0);
    chk("async_summary", 32'(snoop_summary), 32'd0);
    step();
    rst = 1'b0;
    txn(4'b0100, 8'h01, 8'h00, 4'b0100, 2'b00, 4'b0100, 4'b0000);

    // Granted request withdrawn before any command.
    req = 4'b0010;
    step();
    chk("drop_gnt_on", 32'(gnt), 32'h2);
    req = 4'b0000;
    step();
    chk("drop_gnt_off", 32'(gnt), 32'd0);
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_strobe", 32'(snoop_strobe), 32'd0);

    // Randomized traffic, including occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom % 400) == 0;
      req = 4'($urandom_range(0, 15));
      if ($urandom % 3 == 0) req = '0;
      cmd_valid = ($urandom % 4) == 0;
      case ($urandom % 3)
        0:       operation = 8'h01;
        1:       operation = 8'h03;
        default: operation = 8'($urandom);
      endcase
      for (int i = 0; i < R; i++) begin
        case ($urandom % 10)
          0, 1, 2, 3, 4, 5: snoop_result[2*i +: 2] = 2'b00;
          6, 7:             snoop_result[2*i +: 2] = 2'b01;
          8:                snoop_result[2*i +: 2] = 2'b10;
          default:          snoop_result[2*i +: 2] = 2'b11;
        endcase
      end
      done = ($urandom % 3) == 0;
      step();
    end

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
